antilog_share_arbiter: RTL and testbench



---
 rtl/aptpu_log_pkg.sv | 32 +++
 rtl/antilog_share_arbiter_conv.sv | 38 +++
 rtl/antilog_share_arbiter.sv | 144 ++++++++++++++
 tb/tb_antilog_share_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/aptpu_log_pkg.sv
// Shared definitions for the log-domain (approximate TPU) datapath.
//   - Default operand width and mantissa truncation width.
//   - LW_F(): width of one packed log operand for a given configuration.
//   - antilog_ref(): straightforward behavioural antilog for the default
//     configuration, usable as a golden model.
package aptpu_log_pkg;

    localparam int DW_DEF  = 16;
    localparam int T_DEF   = 6;
    localparam int RWD_DEF = 2 * DW_DEF;

    // Log operand = characteristic (clog2(dw)+1 bits) + mantissa (t+1 bits).
    function automatic int LW_F(input int dw, input int t);
        return $clog2(dw) + t + 2;
    endfunction

    localparam int LW_DEF = LW_F(DW_DEF, T_DEF);

    function automatic logic [RWD_DEF-1:0] antilog_ref(input logic [LW_DEF-1:0] l);
        logic [RWD_DEF-1:0] x;
        int k;
        int sh;
        // Implicit leading one followed by the T-1 kept mantissa bits.
        x  = ((RWD_DEF'(l) >> 2) & RWD_DEF'((1 << (T_DEF - 1)) - 1))
           | RWD_DEF'(1 << (T_DEF - 1));
        k  = int'(l >> (T_DEF + 1));
        sh = k - T_DEF + 1;
        if (sh >= 0) return x << sh;
        else         return x >> (-sh);
    endfunction

endpackage

// File: rtl/antilog_share_arbiter_conv.sv
// Combinational antilogarithmic converter.
// Ports:
//   l_i   : log operand {K, mantissa, 2 ignored LSBs}
//   res_o : linear-domain result, 2*DataIN_width bits
// The value is Xt = {1, mantissa[T-1:1]} scaled by 2^(K-T+1); bits shifted
// past the top of the result are dropped.
module antilog_share_arbiter_conv #(
    parameter int DataIN_width     = 16,
    parameter int truncation_width = 6,
    parameter int bw_lg            = $clog2(DataIN_width),
    localparam int LW              = bw_lg + truncation_width + 2,
    localparam int RW              = 2 * DataIN_width
) (
    input  logic [LW-1:0] l_i,
    output logic [RW-1:0] res_o
);

    localparam int T = truncation_width;

    logic        [RW-1:0]    xt_ext;
    logic        [bw_lg:0]   k;
    logic signed [bw_lg+1:0] sub;
    logic        [bw_lg+1:0] rsh;
    logic                    unused_lsb;

    assign xt_ext     = RW'({1'b1, l_i[T:2]});
    assign k          = l_i[T+bw_lg+1:T+1];
    // One extra bit over K so the subtraction is a proper signed value.
    assign sub        = $signed({1'b0, k}) - $signed((bw_lg + 2)'(T - 1));
    assign rsh        = $unsigned(-sub);
    assign unused_lsb = ^l_i[1:0];

    always_comb begin
        if (sub >= 0) res_o = xt_ext << $unsigned(sub);
        else          res_o = xt_ext >> rsh;
    end

endmodule

// File: rtl/antilog_share_arbiter.sv
// Round-robin sharing of one antilog converter among N_REQ log-domain
// requesters, with a two-stage pipeline (operand register, then converter
// into the result register) and valid/ready handshakes on every port.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   req_valid  : per-requester operand valid
//   req_ready  : per-requester accept (at most one bit high)
//   req_data   : packed operands, requester i at [i*LW +: LW]
//   out_valid / out_ready : result handshake
//   out_data   : antilog result; out_id : requester that produced it
//   busy       : either pipeline stage occupied
//   stall_cnt  : saturating count of stalled output cycles
//                (present only when ANTI_STALL_CNT_EN is defined)
module antilog_share_arbiter
    import aptpu_log_pkg::*;
#(
    parameter int DataIN_width     = DW_DEF,
    parameter int truncation_width = T_DEF,
    parameter int bw_lg            = $clog2(DataIN_width),
    parameter int N_REQ            = 4,
    localparam int LW              = bw_lg + truncation_width + 2,
    localparam int IDW             = $clog2(N_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ*LW-1:0]       req_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [2*DataIN_width-1:0] out_data,
    output logic [IDW-1:0]            out_id,
    output logic                      busy
`ifdef ANTI_STALL_CNT_EN
    ,
    output logic [15:0]               stall_cnt
`endif
);

    localparam int RW = 2 * DataIN_width;

    // Returns {found, index}: first valid requester at or after p, wrapping.
    function automatic logic [IDW:0] rr_pick(input logic [N_REQ-1:0] v,
                                             input logic [IDW-1:0]   p);
        logic [IDW:0] r;
        int idx;
        r = '0;
        // Walk from the farthest offset down so the nearest hit wins.
        for (int o = N_REQ - 1; o >= 0; o--) begin
            idx = (int'(p) + o) % N_REQ;
            if (v[IDW'(idx)]) r = {1'b1, IDW'(idx)};
        end
        return r;
    endfunction

    logic [IDW-1:0] ptr_q, ptr_d;
    logic           s1_valid_q, s1_valid_d;
    logic [LW-1:0]  s1_l_q;
    logic [IDW-1:0] s1_id_q;
    logic           out_valid_q;
    logic [RW-1:0]  out_data_q;
    logic [IDW-1:0] out_id_q;

    logic [IDW:0]   pick;
    logic           gnt_vld;
    logic [IDW-1:0] gnt_idx;
    logic           s1_adv, s2_adv, hs;
    logic [RW-1:0]  conv_res;

    assign pick    = rr_pick(req_valid, ptr_q);
    // No grant while in reset so nothing is offered that would be discarded.
    assign gnt_vld = pick[IDW] & ~rst;
    assign gnt_idx = pick[IDW-1:0];
    assign s2_adv  = ~out_valid_q | out_ready;
    assign s1_adv  = ~s1_valid_q | s2_adv;
    assign hs      = gnt_vld & s1_adv;

    always_comb begin
        req_ready          = '0;
        req_ready[gnt_idx] = hs;
    end

    assign ptr_d      = hs ? IDW'((int'(gnt_idx) + 1) % N_REQ) : ptr_q;
    assign s1_valid_d = hs ? 1'b1 : (s1_adv ? 1'b0 : s1_valid_q);

    // ---- stage 1: operand register ----
    always_ff @(posedge clk) begin
        if (hs) begin
            s1_l_q  <= req_data[int'(gnt_idx)*LW +: LW];
            s1_id_q <= gnt_idx;
        end
    end

    antilog_share_arbiter_conv #(
        .DataIN_width    (DataIN_width),
        .truncation_width(truncation_width),
        .bw_lg           (bw_lg)
    ) u_conv (
        .l_i  (s1_l_q),
        .res_o(conv_res)
    );

    // ---- stage 2: result register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
        end else begin
            ptr_q      <= ptr_d;
            s1_valid_q <= s1_valid_d;
            if (s2_adv) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_data_q <= conv_res;
                    out_id_q   <= s1_id_q;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;
    assign busy      = s1_valid_q | out_valid_q;

`ifdef ANTI_STALL_CNT_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst)                           stall_cnt_q <= '0;
        else if (out_valid_q & ~out_ready) stall_cnt_q <= sat_inc16(stall_cnt_q);
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_antilog_share_arbiter.sv
// Directed bench for antilog_share_arbiter (DataIN_width=16, T=6, N_REQ=4,
// LW=12). Expected results are hand-computed constants.
module tb_antilog_share_arbiter;

    localparam int LW = 12;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [47:0] req_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  out_id;
    logic        busy;
`ifdef ANTI_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int total = 0;
    int bad   = 0;
    logic [3:0]  rdy;
    logic [31:0] exp_rr [4];

    always #5 clk = ~clk;

    antilog_share_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_data (req_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_id   (out_id),
        .busy     (busy)
`ifdef ANTI_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int idx, input logic [11:0] l);
        req_data[idx*LW +: LW] = l;
    endtask

    // One isolated request: grant, two-cycle latency, result, then empty.
    task automatic single(input string tag, input int idx, input logic [11:0] l,
                          input logic [31:0] exp);
        req_valid      = '0;
        req_valid[idx] = 1'b1;
        drive(idx, l);
        #1 chk({tag, ".rdy"}, req_ready, 32'd1 << idx);
        step();
        req_valid = '0;
        chk({tag, ".lat1"}, out_valid, 0);
        chk({tag, ".busy1"}, busy, 1);
        step();
        chk({tag, ".valid"}, out_valid, 1);
        chk({tag, ".data"}, out_data, exp);
        chk({tag, ".id"}, out_id, idx);
        step();
        chk({tag, ".drain"}, out_valid, 0);
        chk({tag, ".idle"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        exp_rr    = '{32'd384, 32'd4, 32'd1, 32'h0000FC00};
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        out_ready = 1'b1;
        step();
        step();
        chk("rst.out_valid", out_valid, 0);
        chk("rst.out_data", out_data, 0);
        chk("rst.out_id", out_id, 0);
        chk("rst.busy", busy, 0);
        req_valid = 4'b0001;
        #1 chk("rst.rdy_gated", req_ready, 0);
`ifdef ANTI_STALL_CNT_EN
        chk("rst.stall_cnt", stall_cnt, 0);
`endif
        req_valid = '0;
        rst       = 1'b0;

        // Conversions: left shift, right shifts, top-of-range values.
        single("basic", 0, 12'h440, 32'd384);
        single("rsh3", 0, 12'h100, 32'd4);
        single("rsh5", 2, 12'h000, 32'd1);
        single("lsh10", 3, 12'h7FC, 32'h0000FC00);
        single("max", 1, 12'hFFC, 32'hFC000000);
        single("msb", 2, 12'hF80, 32'h80000000);

        rst = 1'b1;
        step();
        rst = 1'b0;

        // Round robin with all four requesters continuously valid.
        drive(0, 12'h440);
        drive(1, 12'h100);
        drive(2, 12'h000);
        drive(3, 12'h7FC);
        req_valid = 4'hF;
        #1 chk("rr.rdy0", req_ready, 1);
        step();
        for (int k = 0; k < 8; k++) begin
            step();
            chk($sformatf("rr%0d.valid", k), out_valid, 1);
            chk($sformatf("rr%0d.id", k), out_id, k % 4);
            chk($sformatf("rr%0d.data", k), out_data, exp_rr[k % 4]);
            chk($sformatf("rr%0d.rdy", k), req_ready, 32'd1 << ((k + 2) % 4));
        end
        req_valid = '0;
        step();
        chk("rr.tail_id", out_id, 0);
        chk("rr.tail_valid", out_valid, 1);
        step();
        chk("rr.empty", out_valid, 0);
        chk("rr.idle", busy, 0);

        // Backpressure: three requests, output stalled five cycles.
        drive(1, 12'h440);
        drive(2, 12'h100);
        drive(3, 12'h000);
        out_ready = 1'b0;
        req_valid = 4'b1110;
        #1 chk("bp.rdy1", req_ready, 4'b0010);
        rdy = req_ready;
        step();
        req_valid &= ~rdy;
        chk("bp.rdy2", req_ready, 4'b0100);
        rdy = req_ready;
        step();
        req_valid &= ~rdy;
        chk("bp.valid", out_valid, 1);
        chk("bp.id", out_id, 1);
        chk("bp.data", out_data, 384);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp%0d.rdy", k), req_ready, 0);
            step();
            chk($sformatf("bp%0d.id", k), out_id, 1);
            chk($sformatf("bp%0d.data", k), out_data, 384);
            chk($sformatf("bp%0d.busy", k), busy, 1);
        end
`ifdef ANTI_STALL_CNT_EN
        chk("bp.stall_cnt", stall_cnt, 5);
`endif
        out_ready = 1'b1;
        #1 chk("bp.rel_rdy", req_ready, 4'b1000);
        rdy = req_ready;
        step();
        req_valid &= ~rdy;
        chk("bp.r2_valid", out_valid, 1);
        chk("bp.r2_id", out_id, 2);
        chk("bp.r2_data", out_data, 4);
        step();
        chk("bp.r3_valid", out_valid, 1);
        chk("bp.r3_id", out_id, 3);
        chk("bp.r3_data", out_data, 1);
        step();
        chk("bp.empty", out_valid, 0);
        chk("bp.idle", busy, 0);

        // Reset with both stages full; pointer left at 3 beforehand.
        drive(1, 12'h440);
        drive(2, 12'h100);
        req_valid = 4'b0110;
        #1 rdy = req_ready;
        step();
        req_valid &= ~rdy;
        rdy = req_ready;
        step();
        req_valid &= ~rdy;
        chk("mid.full_valid", out_valid, 1);
        chk("mid.full_busy", busy, 1);
        rst       = 1'b1;
        drive(3, 12'h100);
        req_valid = 4'b1010;
        #1 chk("mid.rdy_in_rst", req_ready, 0);
        step();
        chk("mid.out_valid", out_valid, 0);
        chk("mid.busy", busy, 0);
        chk("mid.out_data", out_data, 0);
        chk("mid.out_id", out_id, 0);
        rst = 1'b0;
        #1 chk("mid.grant_low", req_ready, 4'b0010);
        step();
        chk("mid.discarded", out_valid, 0);

        // Sparse traffic: requesters 1 and 3 held valid, no bubbles.
        for (int k = 0; k < 6; k++) begin
            step();
            chk($sformatf("sp%0d.valid", k), out_valid, 1);
            chk($sformatf("sp%0d.id", k), out_id, (k % 2 == 0) ? 1 : 3);
            chk($sformatf("sp%0d.data", k), out_data, (k % 2 == 0) ? 384 : 4);
        end
        req_valid = '0;
        step();
        chk("sp.tail_valid", out_valid, 1);
        step();
        chk("sp.empty", out_valid, 0);
        chk("sp.idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
